// File: rtl/seq_sched_pkg.sv
// Shared types for the sequence-detector scheduler: FSM encodings and requester ids.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves to the loser after every grant.
module rr_arb2
  import seq_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic prio_q;

  // Contention goes to the priority holder; a lone request always wins.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (prio_q == REQ1) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  assign gnt_id = gnt[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= REQ0;
    end else if (en && (|req)) begin
      prio_q <= ~gnt_id;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one serial detector between two word producers: grant, shift MSB-first,
// count detector hits, then hand the count back through a result handshake.
module seq_det_sched
  import seq_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             det_clr,
  output logic             det_x,
  input  logic             det_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             id_q, id_d;
  logic             det_clr_q, det_clr_d;
  logic             det_x_q, det_x_d;
  logic             res_valid_q, res_valid_d;

  logic [1:0] gnt;
  logic       gnt_id;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({req1_valid, req0_valid}),
    .en      (state_q == ST_IDLE),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Next-state and next-output logic; det_x is preloaded with the bit the detector sees next cycle.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    count_d     = count_q;
    id_d        = id_q;
    det_clr_d   = det_clr_q;
    det_x_d     = det_x_q;
    res_valid_d = res_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          shift_d   = (gnt_id == REQ1) ? req1_data : req0_data;
          id_d      = gnt_id;
          count_d   = '0;
          bit_d     = '0;
          state_d   = ST_SHIFT;
          det_clr_d = 1'b0;
          det_x_d   = shift_d[WIDTH-1];
        end
      end
      ST_SHIFT: begin
        if (det_z && (count_q != CNT_MAX)) begin
          count_d = count_q + CNT_W'(1);
        end
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        if (bit_q == LAST_BIT) begin
          state_d     = ST_REPORT;
          det_clr_d   = 1'b1;
          det_x_d     = 1'b0;
          res_valid_d = 1'b1;
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          det_x_d = shift_q[WIDTH-2];
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        det_clr_d   = 1'b1;
        det_x_d     = 1'b0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      count_q     <= '0;
      id_q        <= REQ0;
      det_clr_q   <= 1'b1;
      det_x_q     <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      count_q     <= count_d;
      id_q        <= id_d;
      det_clr_q   <= det_clr_d;
      det_x_q     <= det_x_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign det_clr   = det_clr_q;
  assign det_x     = det_x_q;
  assign res_valid = res_valid_q;
  assign res_id    = id_q;
  assign res_count = count_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched: echo stub or a locking "110" detector model on det_z.
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       det_clr, det_x, det_z;
  logic       res_valid, res_ready, res_id;
  logic [3:0] res_count;

  logic       b_req0_valid, b_req0_ready, b_req1_ready;
  logic [7:0] b_req0_data;
  logic       b_det_clr, b_det_x, b_res_valid, b_res_ready, b_res_id;
  logic [1:0] b_res_count;

  logic       use_model;
  logic [1:0] m_state;
  logic       model_z;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_det_sched #(.WIDTH(8), .CNT_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_clr(det_clr), .det_x(det_x), .det_z(det_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_count(res_count)
  );

  seq_det_sched #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(b_req1_ready),
    .det_clr(b_det_clr), .det_x(b_det_x), .det_z(b_det_x),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_id(b_res_id), .res_count(b_res_count)
  );

  // Mealy detector: "110" enters an absorbing lock state; z=1 on the completing bit and while locked.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || det_clr) m_state <= 2'd0;
    else begin
      case (m_state)
        2'd0:    m_state <= det_x ? 2'd1 : 2'd0;
        2'd1:    m_state <= det_x ? 2'd2 : 2'd0;
        2'd2:    m_state <= det_x ? 2'd2 : 2'd3;
        default: m_state <= 2'd3;
      endcase
    end
  end
  assign model_z = (m_state == 2'd3) || ((m_state == 2'd2) && !det_x);
  assign det_z   = use_model ? model_z : det_x;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_res(input string tag);
    int cyc = 0;
    while (!res_valid && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(res_valid), 32'd1);
  endtask

  initial begin
    logic [7:0] w;
    int clr_run;
    reset_n = 1'b0; use_model = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req1_valid = 1'b0; req1_data = '0; res_ready = 1'b0;
    b_req0_valid = 1'b0; b_req0_data = '0; b_res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clr", 32'(det_clr), 32'd1);
    check("rst_x", 32'(det_x), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    check("rst_count", 32'(res_count), 32'd0);
    check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Test 1: single word A5, bit stream and latency
    w = 8'hA5;
    req0_valid = 1'b1; req0_data = w; #1;
    check("t1_gnt0", 32'({req1_ready, req0_ready}), 32'b01);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_detx", 32'(det_x), 32'(w[7-i]));
      check("t1_clr", 32'(det_clr), 32'd0);
      check("t1_noready", 32'({req1_ready, req0_ready}), 32'd0);
      check("t1_noval", 32'(res_valid), 32'd0);
      req0_valid = 1'b0;
    end
    @(negedge clk);
    check("t1_valid_lat", 32'(res_valid), 32'd1);
    check("t1_id", 32'(res_id), 32'd0);
    check("t1_count", 32'(res_count), 32'd4);
    check("t1_rep_clr", 32'(det_clr), 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    check("t1_consumed", 32'(res_valid), 32'd0);

    // Test 2: contention from reset, round-robin order 0,1,0
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h0F; req1_valid = 1'b1; req1_data = 8'hF0; #1;
    check("t2_gnt_a", 32'({req1_ready, req0_ready}), 32'b01);
    @(negedge clk);
    wait_res("t2_res_a");
    check("t2_id_a", 32'(res_id), 32'd0);
    check("t2_cnt_a", 32'(res_count), 32'd4);
    @(negedge clk);
    check("t2_gnt_b", 32'({req1_ready, req0_ready}), 32'b10);
    @(negedge clk);
    wait_res("t2_res_b");
    check("t2_id_b", 32'(res_id), 32'd1);
    check("t2_cnt_b", 32'(res_count), 32'd4);
    @(negedge clk);
    check("t2_gnt_c", 32'({req1_ready, req0_ready}), 32'b01);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_res("t2_res_c");
    check("t2_id_c", 32'(res_id), 32'd0);
    @(negedge clk);

    // Test 3: stalled result stays stable, no grants while reporting
    res_ready = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h3C; #1;
    check("t3_gnt", 32'({req1_ready, req0_ready}), 32'b10);
    @(negedge clk);
    req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 8'h55;
    wait_res("t3_res");
    for (int i = 0; i < 5; i++) begin
      check("t3_valid", 32'(res_valid), 32'd1);
      check("t3_id", 32'(res_id), 32'd1);
      check("t3_cnt", 32'(res_count), 32'd4);
      check("t3_clr", 32'(det_clr), 32'd1);
      check("t3_noready", 32'({req1_ready, req0_ready}), 32'd0);
      @(negedge clk);
    end
    req0_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check("t3_consumed", 32'(res_valid), 32'd0);

    // Test 4: saturation with a 2-bit counter
    b_req0_valid = 1'b1; b_req0_data = 8'hFF; #1;
    check("t4_gnt", 32'(b_req0_ready), 32'd1);
    @(negedge clk);
    b_req0_valid = 1'b0;
    for (int i = 0; i < 30 && !b_res_valid; i++) @(negedge clk);
    check("t4_valid", 32'(b_res_valid), 32'd1);
    check("t4_sat", 32'(b_res_count), 32'd3);

    // Test 5: locking detector; second word must start from a cleared detector
    use_model = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hD0;
    @(negedge clk);
    req0_data = 8'h01;
    wait_res("t5_res_a");
    check("t5_cnt_a", 32'(res_count), 32'd6);
    clr_run = 0;
    while (det_clr && clr_run < 10) begin
      clr_run++;
      @(negedge clk);
    end
    req0_valid = 1'b0;
    check("t5_clr_gap", 32'(clr_run >= 2), 32'd1);
    wait_res("t5_res_b");
    check("t5_cnt_b", 32'(res_count), 32'd0);
    @(negedge clk);
    use_model = 1'b0;

    // Test 6: reset during the 4th shift cycle discards the word and priority
    req0_valid = 1'b1; req0_data = 8'hFF;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_pre_x", 32'(det_x), 32'd1);
    #1 reset_n = 1'b0; #1;
    check("t6_clr", 32'(det_clr), 32'd1);
    check("t6_x", 32'(det_x), 32'd0);
    check("t6_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h81; req1_valid = 1'b1; req1_data = 8'h7E; #1;
    check("t6_noresult", 32'(res_valid), 32'd0);
    check("t6_gnt", 32'({req1_ready, req0_ready}), 32'b01);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_res("t6_res");
    check("t6_id", 32'(res_id), 32'd0);
    check("t6_cnt", 32'(res_count), 32'd2);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
